cat_trap_board: RTL and testbench

//  Parametrised NxN cat-trap game core: the game state machine, the board memory,
//  a cursor the player steers with buttons, and a pixel renderer on the VGA counters.

---
 rtl/cat_trap_board.sv | 190 +++++++++++++++++++
 tb/tb_cat_trap_board.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cat_trap_board.sv
// Cat-trap game core: game FSM, NxN board memory, wrapping cursor and a
// combinational pixel renderer driven by the VGA counters.
module cat_trap_board #(
  parameter int GRID_N   = 8,
  parameter int CELL_PX  = 50,
  parameter int PITCH_PX = 60,
  parameter int X0       = 222,
  parameter int Y0       = 35,
  parameter int CUR_PX   = 3,
  localparam int CW      = $clog2(GRID_N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bright,
  input  logic [9:0]    hCount,
  input  logic [9:0]    vCount,
  input  logic          btn_up,
  input  logic          btn_down,
  input  logic          btn_left,
  input  logic          btn_right,
  input  logic          btn_center,
  output logic [11:0]   rgb,
  output logic [1:0]    game_state,
  output logic [CW-1:0] cat_row,
  output logic [CW-1:0] cat_col,
  output logic [CW-1:0] cursor_row,
  output logic [CW-1:0] cursor_col,
  output logic [7:0]    move_count
);

  typedef enum logic [2:0] {S_START, S_PLAY, S_CAT_MOVE, S_WIN, S_LOSE} state_t;
  typedef enum logic [1:0] {C_FREE = 2'd0, C_BLOCK = 2'd1, C_CAT = 2'd2} cell_t;

  localparam logic [CW-1:0] MAX_IDX = CW'(GRID_N - 1);
  localparam logic [CW-1:0] CTR_IDX = CW'(GRID_N / 2);

  state_t          state_q, state_d;
  cell_t           board_q [GRID_N][GRID_N];
  logic [CW-1:0]   cur_row_q, cur_row_d, cur_col_q, cur_col_d;
  logic [CW-1:0]   cat_row_q, cat_row_d, cat_col_q, cat_col_d;
  logic [CW-1:0]   cat_dn, cat_up, cat_rt, cat_lt;
  logic [7:0]      move_cnt_q;
  logic            place_blk, reinit, cat_step;

  assign cat_dn = cat_row_q + 1'b1;
  assign cat_up = cat_row_q - 1'b1;
  assign cat_rt = cat_col_q + 1'b1;
  assign cat_lt = cat_col_q - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_START;
    else       state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    cur_row_d = cur_row_q;
    cur_col_d = cur_col_q;
    cat_row_d = cat_row_q;
    cat_col_d = cat_col_q;
    place_blk = 1'b0;
    reinit    = 1'b0;
    cat_step  = 1'b0;
    case (state_q)
      S_START: if (btn_center) state_d = S_PLAY;
      S_PLAY: begin
        if (btn_center) begin
          if (board_q[cur_row_q][cur_col_q] == C_FREE) begin
            place_blk = 1'b1;
            state_d   = S_CAT_MOVE;
          end
        end else if (btn_up)    cur_row_d = (cur_row_q == '0)      ? MAX_IDX : cur_row_q - 1'b1;
        else if (btn_down)      cur_row_d = (cur_row_q == MAX_IDX) ? '0      : cur_row_q + 1'b1;
        else if (btn_left)      cur_col_d = (cur_col_q == '0)      ? MAX_IDX : cur_col_q - 1'b1;
        else if (btn_right)     cur_col_d = (cur_col_q == MAX_IDX) ? '0      : cur_col_q + 1'b1;
      end
      S_CAT_MOVE: begin
        // The cat is interior here, so all four neighbour indices are in range.
        cat_step = 1'b1;
        if      (board_q[cat_dn][cat_col_q] == C_FREE) cat_row_d = cat_dn;
        else if (board_q[cat_up][cat_col_q] == C_FREE) cat_row_d = cat_up;
        else if (board_q[cat_row_q][cat_rt] == C_FREE) cat_col_d = cat_rt;
        else if (board_q[cat_row_q][cat_lt] == C_FREE) cat_col_d = cat_lt;
        else cat_step = 1'b0;
        if (!cat_step) state_d = S_WIN;
        else if (cat_row_d == '0 || cat_row_d == MAX_IDX ||
                 cat_col_d == '0 || cat_col_d == MAX_IDX) state_d = S_LOSE;
        else state_d = S_PLAY;
      end
      S_WIN, S_LOSE: begin
        if (btn_center) begin
          reinit  = 1'b1;
          state_d = S_START;
        end
      end
      default: state_d = S_START;
    endcase
  end

  // NOTE: the board is small register storage, so it is reset; a RAM-style array would not be.
  always_ff @(posedge clk) begin
    if (reset || reinit) begin
      for (int r = 0; r < GRID_N; r++)
        for (int c = 0; c < GRID_N; c++)
          board_q[r][c] <= (r == GRID_N / 2 && c == GRID_N / 2) ? C_CAT : C_FREE;
      cur_row_q  <= '0;
      cur_col_q  <= '0;
      cat_row_q  <= CTR_IDX;
      cat_col_q  <= CTR_IDX;
      move_cnt_q <= '0;
    end else begin
      cur_row_q <= cur_row_d;
      cur_col_q <= cur_col_d;
      if (place_blk) begin
        board_q[cur_row_q][cur_col_q] <= C_BLOCK;
        if (move_cnt_q != 8'hFF) move_cnt_q <= move_cnt_q + 8'd1;
      end
      if (cat_step) begin
        board_q[cat_row_q][cat_col_q] <= C_FREE;
        board_q[cat_row_d][cat_col_d] <= C_CAT;
        cat_row_q <= cat_row_d;
        cat_col_q <= cat_col_d;
      end
    end
  end

  // Renderer: locate the cell under the beam in 11-bit space so large grids clip.
  logic [10:0]   h_ext, v_ext, x_rel, y_rel;
  logic          in_x, in_y, on_border;
  logic [CW-1:0] px_row, px_col;

  assign h_ext = {1'b0, hCount};
  assign v_ext = {1'b0, vCount};

  always_comb begin
    in_x = 1'b0; px_col = '0; x_rel = '0;
    in_y = 1'b0; px_row = '0; y_rel = '0;
    for (int i = 0; i < GRID_N; i++) begin
      if (h_ext >= 11'(X0 + i * PITCH_PX) && h_ext < 11'(X0 + i * PITCH_PX + CELL_PX)) begin
        in_x   = 1'b1;
        px_col = CW'(i);
        x_rel  = h_ext - 11'(X0 + i * PITCH_PX);
      end
      if (v_ext >= 11'(Y0 + i * PITCH_PX) && v_ext < 11'(Y0 + i * PITCH_PX + CELL_PX)) begin
        in_y   = 1'b1;
        px_row = CW'(i);
        y_rel  = v_ext - 11'(Y0 + i * PITCH_PX);
      end
    end
  end

  assign on_border = (x_rel < 11'(CUR_PX)) || (x_rel >= 11'(CELL_PX - CUR_PX)) ||
                     (y_rel < 11'(CUR_PX)) || (y_rel >= 11'(CELL_PX - CUR_PX));

  always_comb begin
    rgb = 12'h000;
    if (bright) begin
      if (in_x && in_y) begin
        if (state_q == S_PLAY && px_row == cur_row_q && px_col == cur_col_q && on_border)
          rgb = 12'h00F;
        else begin
          case (board_q[px_row][px_col])
            C_BLOCK: rgb = 12'h888;
            C_CAT:   rgb = 12'hF80;
            default: rgb = 12'hFFF;
          endcase
        end
      end else if (state_q == S_WIN)  rgb = 12'h0F0;
      else if (state_q == S_LOSE)     rgb = 12'hF00;
      else                            rgb = 12'hFFF;
    end
  end

  always_comb begin
    case (state_q)
      S_START:            game_state = 2'd0;
      S_PLAY, S_CAT_MOVE: game_state = 2'd1;
      S_WIN:              game_state = 2'd2;
      default:            game_state = 2'd3;
    endcase
  end

  assign cat_row    = cat_row_q;
  assign cat_col    = cat_col_q;
  assign cursor_row = cur_row_q;
  assign cursor_col = cur_col_q;
  assign move_count = move_cnt_q;

endmodule

// File: tb/tb_cat_trap_board.sv
// Bench for cat_trap_board: an 8x8 instance (a) and a 5x5 instance (b) driven
// against a small game model; cat-step results flow through a scoreboard queue.
module tb_cat_trap_board;

  localparam logic [4:0] B_C = 5'b10000;
  localparam logic [4:0] B_U = 5'b01000;
  localparam logic [4:0] B_D = 5'b00100;
  localparam logic [4:0] B_L = 5'b00010;
  localparam logic [4:0] B_R = 5'b00001;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, reset_b, bright;
  logic [9:0]  h_a, v_a, h_b, v_b;
  logic [4:0]  btn_a, btn_b;
  logic [11:0] rgb_a, rgb_b;
  logic [1:0]  gs_a, gs_b;
  logic [2:0]  cr_a, cc_a, ur_a, uc_a, cr_b, cc_b, ur_b, uc_b;
  logic [7:0]  mc_a, mc_b;

  int checks = 0;
  int errors = 0;

  cat_trap_board #(.GRID_N(8)) dut_a (
    .clk(clk), .reset(reset_a), .bright(bright), .hCount(h_a), .vCount(v_a),
    .btn_up(btn_a[3]), .btn_down(btn_a[2]), .btn_left(btn_a[1]), .btn_right(btn_a[0]),
    .btn_center(btn_a[4]), .rgb(rgb_a), .game_state(gs_a), .cat_row(cr_a), .cat_col(cc_a),
    .cursor_row(ur_a), .cursor_col(uc_a), .move_count(mc_a)
  );

  cat_trap_board #(.GRID_N(5)) dut_b (
    .clk(clk), .reset(reset_b), .bright(bright), .hCount(h_b), .vCount(v_b),
    .btn_up(btn_b[3]), .btn_down(btn_b[2]), .btn_left(btn_b[1]), .btn_right(btn_b[0]),
    .btn_center(btn_b[4]), .rgb(rgb_b), .game_state(gs_b), .cat_row(cr_b), .cat_col(cc_b),
    .cursor_row(ur_b), .cursor_col(uc_b), .move_count(mc_b)
  );

  // Game model: board cells 0=free 1=block 2=cat, state 0..3 as reported.
  int mb [2][16][16];
  int mcr [2], mcc [2], mur [2], muc [2], mcnt [2], mst [2];

  typedef struct {
    int          d;
    logic [21:0] v;
  } exp_t;
  exp_t sb [$];

  function automatic int gn(input int d);
    return (d == 0) ? 8 : 5;
  endfunction

  function automatic logic [21:0] snap(input int d);
    if (d == 0) return {gs_a, cr_a, cc_a, ur_a, uc_a, mc_a};
    return {gs_b, cr_b, cc_b, ur_b, uc_b, mc_b};
  endfunction

  function automatic logic [21:0] mk(input int d);
    return {2'(mst[d]), 3'(mcr[d]), 3'(mcc[d]), 3'(mur[d]), 3'(muc[d]), 8'(mcnt[d])};
  endfunction

  task automatic model_init(input int d);
    int ctr;
    ctr = gn(d) / 2;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mb[d][r][c] = 0;
    mb[d][ctr][ctr] = 2;
    mcr[d] = ctr; mcc[d] = ctr; mur[d] = 0; muc[d] = 0; mcnt[d] = 0; mst[d] = 0;
  endtask

  task automatic model_cat(input int d);
    int dr [4] = '{1, -1, 0, 0};
    int dc [4] = '{0, 0, 1, -1};
    int n;
    bit moved;
    n = gn(d);
    moved = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!moved && mb[d][mcr[d] + dr[k]][mcc[d] + dc[k]] == 0) begin
        mb[d][mcr[d]][mcc[d]] = 0;
        mcr[d] += dr[k];
        mcc[d] += dc[k];
        mb[d][mcr[d]][mcc[d]] = 2;
        moved = 1'b1;
      end
    end
    if (!moved) mst[d] = 2;
    else if (mcr[d] == 0 || mcr[d] == n - 1 || mcc[d] == 0 || mcc[d] == n - 1) mst[d] = 3;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle button pulse; model advances and center presses in PLAY queue their result.
  task automatic press(input int d, input logic [4:0] b);
    int n;
    n = gn(d);
    if (d == 0) btn_a = b; else btn_b = b;
    tick();
    btn_a = '0;
    btn_b = '0;
    case (mst[d])
      0: if (b[4]) mst[d] = 1;
      1: begin
        if (b[4]) begin
          if (mb[d][mur[d]][muc[d]] == 0) begin
            mb[d][mur[d]][muc[d]] = 1;
            if (mcnt[d] < 255) mcnt[d]++;
            model_cat(d);
          end
          sb.push_back('{d, mk(d)});
        end
        else if (b[3]) mur[d] = (mur[d] + n - 1) % n;
        else if (b[2]) mur[d] = (mur[d] + 1) % n;
        else if (b[1]) muc[d] = (muc[d] + n - 1) % n;
        else if (b[0]) muc[d] = (muc[d] + 1) % n;
      end
      default: if (b[4]) model_init(d);
    endcase
  endtask

  task automatic drain();
    exp_t e;
    tick();
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty got=%0d want>0", sb.size());
    end else begin
      e = sb.pop_front();
      if (snap(e.d) !== e.v) begin
        errors++;
        $display("FAIL cat_step dut=%0d got=%h want=%h", e.d, snap(e.d), e.v);
      end
    end
  endtask

  task automatic place(input int d);
    press(d, B_C);
    drain();
  endtask

  task automatic move_to(input int d, input int r, input int c);
    for (int i = 0; i < 16 && mur[d] != r; i++) press(d, B_D);
    for (int i = 0; i < 16 && muc[d] != c; i++) press(d, B_R);
  endtask

  task automatic pix(input int d, input int x, input int y, output logic [11:0] col);
    if (d == 0) begin h_a = 10'(x); v_a = 10'(y); end
    else        begin h_b = 10'(x); v_b = 10'(y); end
    @(negedge clk);
    col = (d == 0) ? rgb_a : rgb_b;
  endtask

  task automatic do_reset(input int d);
    if (d == 0) reset_a = 1'b1; else reset_b = 1'b1;
    tick();
    tick();
    reset_a = 1'b0;
    reset_b = 1'b0;
    model_init(d);
  endtask

  task automatic test_reset();
    logic [11:0] c;
    do_reset(0);
    do_reset(1);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL reset_state_a got=%h want=%h", snap(0), mk(0)); end
    checks++; if (snap(1) !== mk(1)) begin errors++; $display("FAIL reset_state_b got=%h want=%h", snap(1), mk(1)); end
    pix(0, 247, 60, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL reset_free_pixel got=%h want=FFF", c); end
    pix(0, 487, 300, c);
    checks++; if (c !== 12'hF80) begin errors++; $display("FAIL reset_cat_pixel got=%h want=F80", c); end
    pix(0, 10, 10, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL reset_outside got=%h want=FFF", c); end
    bright = 1'b0;
    pix(0, 487, 300, c);
    checks++; if (c !== 12'h000) begin errors++; $display("FAIL blank_pixel got=%h want=000", c); end
    bright = 1'b1;
  endtask

  task automatic test_start_ignores();
    press(0, B_U);
    press(0, B_R);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL start_ignores got=%h want=%h", snap(0), mk(0)); end
    press(0, B_C);
    checks++; if (gs_a !== 2'd1) begin errors++; $display("FAIL start_to_play got=%0d want=1", gs_a); end
  endtask

  task automatic test_cursor_wrap();
    logic [11:0] c;
    press(0, B_U);
    checks++; if (ur_a !== 3'd7) begin errors++; $display("FAIL wrap_up got=%0d want=7", ur_a); end
    press(0, B_L);
    checks++; if (uc_a !== 3'd7) begin errors++; $display("FAIL wrap_left got=%0d want=7", uc_a); end
    press(0, B_D);
    checks++; if (ur_a !== 3'd0) begin errors++; $display("FAIL wrap_down got=%0d want=0", ur_a); end
    press(0, B_R);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL wrap_right got=%h want=%h", snap(0), mk(0)); end
    pix(0, 224, 37, c);
    checks++; if (c !== 12'h00F) begin errors++; $display("FAIL outline_inner_edge got=%h want=00F", c); end
    pix(0, 225, 60, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL outline_left_limit got=%h want=FFF", c); end
    pix(0, 269, 60, c);
    checks++; if (c !== 12'h00F) begin errors++; $display("FAIL outline_right got=%h want=00F", c); end
    pix(0, 268, 60, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL outline_right_limit got=%h want=FFF", c); end
  endtask

  task automatic test_block();
    logic [11:0] c;
    move_to(0, 5, 4);
    place(0);
    pix(0, 487, 360, c);
    checks++; if (c !== 12'h888) begin errors++; $display("FAIL block_pixel got=%h want=888", c); end
    place(0);
    move_to(0, 3, 4);
    place(0);
  endtask

  task automatic test_win();
    logic [11:0] c;
    int seq [7][2] = '{'{5, 4}, '{2, 4}, '{4, 5}, '{3, 5}, '{4, 3}, '{3, 3}, '{3, 4}};
    do_reset(0);
    press(0, B_C);
    foreach (seq[i]) begin
      move_to(0, seq[i][0], seq[i][1]);
      place(0);
    end
    checks++; if (gs_a !== 2'd2) begin errors++; $display("FAIL win_state got=%0d want=2", gs_a); end
    pix(0, 5, 5, c);
    checks++; if (c !== 12'h0F0) begin errors++; $display("FAIL win_outside got=%h want=0F0", c); end
    pix(0, 272, 60, c);
    checks++; if (c !== 12'h0F0) begin errors++; $display("FAIL win_gap got=%h want=0F0", c); end
    pix(0, 463, 216, c);
    checks++; if (c !== 12'h888) begin errors++; $display("FAIL win_no_outline got=%h want=888", c); end
    press(0, B_U);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL win_frozen got=%h want=%h", snap(0), mk(0)); end
    press(0, B_C);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL restart got=%h want=%h", snap(0), mk(0)); end
    pix(0, 487, 240, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL restart_board got=%h want=FFF", c); end
  endtask

  task automatic test_lose();
    logic [11:0] c;
    press(1, B_C);
    move_to(1, 3, 2);
    place(1);
    move_to(1, 2, 2);
    place(1);
    checks++; if (gs_b !== 2'd3) begin errors++; $display("FAIL lose_state got=%0d want=3", gs_b); end
    pix(1, 5, 5, c);
    checks++; if (c !== 12'hF00) begin errors++; $display("FAIL lose_outside got=%h want=F00", c); end
    pix(1, 367, 60, c);
    checks++; if (c !== 12'hF80) begin errors++; $display("FAIL lose_cat_pixel got=%h want=F80", c); end
    pix(1, 367, 120, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL lose_vacated got=%h want=FFF", c); end
  endtask

  task automatic test_priority_reset();
    logic [11:0] c;
    press(0, B_C);
    press(0, B_C | B_U);
    checks++; if ({gs_a, ur_a, uc_a, mc_a} !== {2'd1, 3'd0, 3'd0, 8'd1}) begin
      errors++; $display("FAIL center_priority got=%h want=%h", {gs_a, ur_a, uc_a, mc_a}, {2'd1, 3'd0, 3'd0, 8'd1});
    end
    pix(0, 247, 60, c);
    checks++; if (c !== 12'h888) begin errors++; $display("FAIL block_next_cycle got=%h want=888", c); end
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    sb.delete();
    model_init(0);
    checks++; if (snap(0) !== mk(0)) begin errors++; $display("FAIL midgame_reset got=%h want=%h", snap(0), mk(0)); end
    pix(0, 247, 60, c);
    checks++; if (c !== 12'hFFF) begin errors++; $display("FAIL reset_clears_board got=%h want=FFF", c); end
    pix(0, 487, 300, c);
    checks++; if (c !== 12'hF80) begin errors++; $display("FAIL reset_cat_home got=%h want=F80", c); end
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1; bright = 1'b1;
    h_a = '0; v_a = '0; h_b = '0; v_b = '0;
    btn_a = '0; btn_b = '0;
    model_init(0);
    model_init(1);
    test_reset();
    test_start_ignores();
    test_cursor_wrap();
    test_block();
    test_win();
    test_lose();
    test_priority_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
